pe_line_buffer: RTL and testbench
=================================

# pe_line_buffer

Double-buffered scanline buffer directly downstream of the priority-evaluation FSM. It captures one final 15-bit BGR555 pixel per evaluated column into a write bank. When the last column lands, that bank becomes full. It then streams the full bank to the display/blend stage over a valid/ready handshake while the other bank fills, decoupling the 4-cycle-per-pixel evaluation cadence from display backpressure.

## Interface
- LINE_W, default 160: pixels per line; also the column wrap point of the evaluator.
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- pixel_valid  in  1  one-cycle strobe: final pixel for pixel_col is on pixel_color.
- pixel_col  in  8  column index, 0..LINE_W-1.
- pixel_color  in  15  evaluated colour.
- out_valid  out  1  out_color/out_col/out_last hold a pixel.
- out_ready  in  1  consumer accepts the pixel this cycle.
- out_color  out  15  streamed pixel colour.
- out_col  out  8  column of streamed pixel.
- out_last  out  1  high with column LINE_W-1.
- overflow  out  1  sticky: a pixel was dropped.
- drop_count  out  16  saturating dropped-pixel count; present only with PE_LBUF_DROPCNT_EN.

## Operation
- State bits: wr_bank, rd_bank, bank_full[1:0], rd_col, read FSM.
- Write side, on pixel_valid:
  - Accepted when pixel_col < LINE_W and !bank_full[wr_bank]. The write goes to mem[wr_bank][pixel_col].
  - Accepted with pixel_col == LINE_W-1: set bank_full[wr_bank] and toggle wr_bank.
  - Otherwise (bank full or col out of range): drop the pixel, set overflow, and increment drop_count.
- Read FSM, states IDLE, FETCH, SEND:
  - IDLE: if bank_full[rd_bank], set rd_col=0 and go to FETCH.
  - FETCH: present address {rd_bank, rd_col} to the synchronous RAM, then go to SEND.
  - SEND: out_valid=1 with registered RAM data. On out_valid&&out_ready:
    - If out_last: clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
    - Else: increment rd_col and go to FETCH.
  - Without out_ready, stay in SEND with all outputs stable.
- Writer sets bits only on a non-full bank, and reader clears bits only on a full bank. A same-cycle set and clear therefore always hit different bits, and both take effect.
- Lines are emitted strictly in fill order. Columns within a line are emitted 0..LINE_W-1 regardless of write order; unwritten columns emit stale RAM contents.

## Timing
- Reset values: out_valid=0, out_color=0, out_col=0, out_last=0, overflow=0, drop_count=0, bank_full=0, wr_bank=0, rd_bank=0, FSM=IDLE. RAM contents are not reset.
- Reset mid-line or mid-stream discards all partial and full lines. out_valid is low from reset assertion.
- Write of column LINE_W-1 at cycle T sets bank_full at edge T. Schedule:
  - T+1: IDLE
  - T+2: FETCH
  - T+3: first out_valid
- Throughput with out_ready held high: one pixel per 2 cycles. This exceeds the evaluator's one pixel per 4 cycles.
- drop_count saturates at 16'hFFFF. overflow clears only on reset.

## Configuration
- PE_LBUF_DROPCNT_EN defined: drop_count port and 16-bit saturating counter exist.
- PE_LBUF_DROPCNT_EN undefined: the port and counter are absent. overflow still operates.

## Structure
- Package pe_pkg holds:
  - color_t (logic [14:0])
  - PE_LINE_W constant (160)
  - lbuf_state_t enum {IDLE, FETCH, SEND}
- Sub-module pe_line_ram holds the storage:
  - 2*LINE_W x 15 simple dual-port RAM.
  - One write port and one registered read port.
  - Address = {bank, col}.

## Test plan
- Write cols 0..159 with color=col, out_ready=1 -> 160 beats in order, colors 0..159, out_last only at col 159, first out_valid 3 cycles after the col-159 strobe.
- Stream with out_ready low for 10 cycles at col 50 -> out_valid stays 1; out_col=50 and out_color stable until ready; no beat lost or duplicated.
- Hold out_ready=0, fill two full lines, then strobe col 0 color 7FFF -> pixel dropped, overflow=1, drop_count=1 (macro on). Then release ready -> first line streams intact.
- Strobe pixel_col=200 -> no RAM write, overflow=1, drop_count increments.
- Fill line A (color 0x001F) while streaming, then fill line B (0x03E0) during A's readout -> A's 160 beats precede B's 160 beats, no drops.
- Assert reset at beat 80 of a stream -> out_valid=0 immediately. After release, outputs read 0 and nothing streams until a new full line is written.

Source files
------------

// File: rtl/pe_line_buffer_pkg.sv
// Shared types and constants for the priority-evaluator scanline buffer.
package pe_pkg;

  typedef logic [14:0] color_t;

  localparam int PE_LINE_W = 160;
  localparam int PE_COL_W  = 8;

  typedef logic [PE_COL_W-1:0] col_t;
  typedef logic [PE_COL_W:0]   lbuf_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } lbuf_state_t;

  // RAM address is the bank bit stacked on top of the column index.
  function automatic lbuf_addr_t lbufAddr(input logic bank, input col_t col);
    return {bank, col};
  endfunction

endpackage

// File: rtl/pe_line_buffer_if.sv
// Pixel stream from the line buffer to the display/blend stage.
// The buffer drives through the master modport, the consumer through slave.
interface pe_line_buffer_if import pe_pkg::*; ();

  logic   out_valid;
  logic   out_ready;
  color_t out_color;
  col_t   out_col;
  logic   out_last;

  modport master (
    output out_valid,
    output out_color,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_color,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pe_line_buffer_ram.sv
// Two-bank scanline storage: one write port, one registered read port.
// Addresses arrive as {bank, col}; banks are packed back to back so only
// 2*LINE_W words are needed.
module pe_line_ram import pe_pkg::*; #(
  parameter int LINE_W = PE_LINE_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en_i,
  input  lbuf_addr_t wr_addr_i,
  input  color_t     wr_data_i,
  input  logic       rd_en_i,
  input  lbuf_addr_t rd_addr_i,
  output color_t     rd_data_o
);

  localparam int DEPTH = 2 * LINE_W;
  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  color_t mem [DEPTH];
  color_t rdData_q;

  // Bank 1 starts right after the last column of bank 0.
  function automatic idx_t toIndex(input lbuf_addr_t addr);
    idx_t base;
    base = addr[PE_COL_W] ? idx_t'(LINE_W) : '0;
    return base + idx_t'(addr[PE_COL_W-1:0]);
  endfunction

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[toIndex(wr_addr_i)] <= wr_data_i;
    end
  end

  // Read register only loads on request so the output holds during stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= mem[toIndex(rd_addr_i)];
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/pe_line_buffer.sv
// Double-buffered scanline buffer behind the priority evaluator.
// One bank fills from the evaluator while the other streams out.
// Build option PE_LBUF_DROPCNT_EN adds the saturating drop_count output.
module pe_line_buffer import pe_pkg::*; #(
  parameter int LINE_W = PE_LINE_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pixel_valid,
  input  col_t                    pixel_col,
  input  color_t                  pixel_color,
  pe_line_buffer_if.master        bus,
  output logic                    overflow
`ifdef PE_LBUF_DROPCNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam lbuf_addr_t LINE_W_EXT = lbuf_addr_t'(LINE_W);
  localparam col_t       LAST_COL   = col_t'(LINE_W - 1);

  logic        wrBank_q, wrBank_d;
  logic        rdBank_q, rdBank_d;
  logic [1:0]  bankFull_q, bankFull_d;
  col_t        rdCol_q, rdCol_d;
  lbuf_state_t state_q, state_d;
  logic        overflow_q, overflow_d;
`ifdef PE_LBUF_DROPCNT_EN
  logic [15:0] dropCount_q, dropCount_d;
`endif

  logic   wrAccept;
  logic   wrDrop;
  logic   wrLineDone;
  logic   rdLineDone;
  logic   ramRdEn;
  color_t ramData;

  // Decide whether an incoming pixel lands in the write bank or is dropped.
  always_comb begin
    wrAccept   = 1'b0;
    wrDrop     = 1'b0;
    wrLineDone = 1'b0;
    if (pixel_valid) begin
      if (({1'b0, pixel_col} < LINE_W_EXT) && !bankFull_q[wrBank_q]) begin
        wrAccept   = 1'b1;
        wrLineDone = (pixel_col == LAST_COL);
      end else begin
        wrDrop = 1'b1;
      end
    end
  end

  // Read sequencer: wait for a full bank, then fetch/send one column at a time.
  always_comb begin
    state_d    = state_q;
    rdCol_d    = rdCol_q;
    rdBank_d   = rdBank_q;
    rdLineDone = 1'b0;
    ramRdEn    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bankFull_q[rdBank_q]) begin
          rdCol_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ramRdEn = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (rdCol_q == LAST_COL) begin
            rdLineDone = 1'b1;
            rdBank_d   = ~rdBank_q;
            state_d    = IDLE;
          end else begin
            rdCol_d = rdCol_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bank ownership and drop bookkeeping; set and clear never hit the same bank.
  always_comb begin
    wrBank_d   = wrBank_q;
    bankFull_d = bankFull_q;
    overflow_d = overflow_q | wrDrop;
    if (wrLineDone) begin
      bankFull_d[wrBank_q] = 1'b1;
      wrBank_d             = ~wrBank_q;
    end
    if (rdLineDone) begin
      bankFull_d[rdBank_q] = 1'b0;
    end
  end

`ifdef PE_LBUF_DROPCNT_EN
  // Dropped-pixel counter sticks at all-ones instead of wrapping.
  always_comb begin
    dropCount_d = dropCount_q;
    if (wrDrop && (dropCount_q != 16'hFFFF)) begin
      dropCount_d = dropCount_q + 16'd1;
    end
  end
`endif

  // State register for both write and read sides.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b0;
      bankFull_q  <= 2'b00;
      rdCol_q     <= '0;
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
`ifdef PE_LBUF_DROPCNT_EN
      dropCount_q <= 16'd0;
`endif
    end else begin
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      bankFull_q  <= bankFull_d;
      rdCol_q     <= rdCol_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
`ifdef PE_LBUF_DROPCNT_EN
      dropCount_q <= dropCount_d;
`endif
    end
  end

  pe_line_ram #(
    .LINE_W (LINE_W)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wrAccept),
    .wr_addr_i (lbufAddr(wrBank_q, pixel_col)),
    .wr_data_i (pixel_color),
    .rd_en_i   (ramRdEn),
    .rd_addr_i (lbufAddr(rdBank_q, rdCol_q)),
    .rd_data_o (ramData)
  );

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_color = ramData;
  assign bus.out_col   = rdCol_q;
  assign bus.out_last  = (state_q == SEND) && (rdCol_q == LAST_COL);
  assign overflow      = overflow_q;
`ifdef PE_LBUF_DROPCNT_EN
  assign drop_count    = dropCount_q;
`endif

endmodule

// File: tb/tb_pe_line_buffer.sv
// Scoreboard bench for pe_line_buffer: a line-level model predicts every
// beat when the closing column is written; a monitor checks the stream.
module tb_pe_line_buffer;
  import pe_pkg::*;

  localparam int LINE_W = PE_LINE_W;

  typedef struct {
    color_t color;
    col_t   col;
    logic   last;
    logic   known;
  } beat_t;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   pixel_valid = 1'b0;
  col_t   pixel_col = '0;
  color_t pixel_color = '0;
  logic   overflow;
`ifdef PE_LBUF_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  pe_line_buffer_if bus ();

  pe_line_buffer #(.LINE_W(LINE_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .pixel_col   (pixel_col),
    .pixel_color (pixel_color),
    .bus         (bus),
    .overflow    (overflow)
`ifdef PE_LBUF_DROPCNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  color_t modelMem [2][LINE_W];
  bit     modelKnown [2][LINE_W];
  int     modelWrBank = 0;
  int     outstanding = 0;
  beat_t  expQ [$];
  bit     expOverflow = 1'b0;
  int     expDrops = 0;

  int beatsAccepted = 0;
  int validRiseCycle = -1;
  int readyMode = 0;
  int stallLeft = 0;
  bit stallDone = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one pixel strobe for a single cycle and update the line model.
  task automatic applyStimulus(input int col, input color_t color);
    pixel_valid = 1'b1;
    pixel_col   = col[7:0];
    pixel_color = color;
    if (col < LINE_W && outstanding < 2) begin
      modelMem[modelWrBank][col]   = color;
      modelKnown[modelWrBank][col] = 1'b1;
      if (col == LINE_W - 1) begin
        for (int c = 0; c < LINE_W; c++) begin
          beat_t b;
          b.color = modelMem[modelWrBank][c];
          b.col   = c[7:0];
          b.last  = (c == LINE_W - 1);
          b.known = modelKnown[modelWrBank][c];
          expQ.push_back(b);
        end
        outstanding++;
        modelWrBank = 1 - modelWrBank;
      end
    end else begin
      expOverflow = 1'b1;
      if (expDrops < 65535) expDrops++;
    end
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic fillLine(input int gap, input bit randColor, input color_t color);
    for (int c = 0; c < LINE_W; c++) begin
      applyStimulus(c, randColor ? color_t'($urandom) : color);
      idle(gap);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || outstanding != 0) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drain remaining beats", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(expOverflow));
`ifdef PE_LBUF_DROPCNT_EN
    checkOutput({tag, " drop_count"}, 32'(drop_count), 32'(expDrops));
`endif
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " outputs"},
                32'({bus.out_valid, bus.out_color, bus.out_col, bus.out_last}),
                32'd0);
  endtask

  // Consumer ready pattern, selected by readyMode.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        2: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stallLeft > 0) begin
            bus.out_ready = 1'b0;
            stallLeft--;
          end else if (!stallDone && bus.out_valid && bus.out_col == 8'd50) begin
            bus.out_ready = 1'b0;
            stallLeft = 9;
            stallDone = 1'b1;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pop the expected beat on each handshake and check stall stability.
  initial begin
    bit     prevStall;
    bit     prevValid;
    color_t heldColor;
    col_t   heldCol;
    logic   heldLast;
    beat_t  b;
    prevStall = 1'b0;
    prevValid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall = 1'b0;
        prevValid = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stalled beat held",
                      32'({bus.out_valid, bus.out_color, bus.out_col, bus.out_last}),
                      32'({1'b1, heldColor, heldCol, heldLast}));
        end
        if (bus.out_valid && !prevValid && validRiseCycle < 0) validRiseCycle = cycle;
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected beat: got col %0d color %0h, expected no beat",
                     bus.out_col, bus.out_color);
          end else begin
            b = expQ.pop_front();
            checkOutput("beat col/last", 32'({bus.out_col, bus.out_last}), 32'({b.col, b.last}));
            if (b.known) checkOutput("beat color", 32'(bus.out_color), 32'(b.color));
            if (b.last) outstanding--;
          end
          beatsAccepted++;
        end
        prevStall = bus.out_valid && !bus.out_ready;
        prevValid = bus.out_valid;
        heldColor = bus.out_color;
        heldCol   = bus.out_col;
        heldLast  = bus.out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int order [LINE_W];
    int cnt;
    int j;
    int tmp;

    // Reset values, during and after reset.
    #12;
    checkIdleOutputs("in reset");
    checkStatus("in reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    checkIdleOutputs("after reset");

    // Line with color=col, evaluator cadence, consumer always ready.
    readyMode = 0;
    for (int c = 0; c < LINE_W; c++) begin
      if (c == LINE_W - 1) begin
        validRiseCycle = -1;
        base = cycle;
      end
      applyStimulus(c, color_t'(c));
      if (c != LINE_W - 1) idle(3);
    end
    n = 0;
    while (validRiseCycle < 0 && n < 20) begin
      idle(1);
      n++;
    end
    checkOutput("first out_valid latency", 32'(validRiseCycle - base), 32'd3);
    waitDrain(2000);

    // Ten-cycle stall at column 50.
    readyMode = 3;
    stallDone = 1'b0;
    fillLine(1, 1'b1, '0);
    waitDrain(2000);
    checkOutput("stall at col 50 exercised", 32'(stallDone), 32'd1);

    // Both banks full under backpressure, then one more pixel is dropped.
    readyMode = 1;
    fillLine(0, 1'b1, '0);
    fillLine(0, 1'b1, '0);
    applyStimulus(0, 15'h7FFF);
    checkStatus("bank-full drop");
    checkOutput("stalled first beat", 32'({bus.out_valid, bus.out_col}), 32'({1'b1, 8'd0}));
    readyMode = 0;
    waitDrain(3000);

    // Out-of-range column.
    applyStimulus(200, color_t'($urandom));
    checkStatus("col 200 drop");

    // Line A then line B written during A's readout.
    readyMode = 2;
    fillLine(0, 1'b0, 15'h001F);
    fillLine(0, 1'b0, 15'h03E0);
    checkStatus("A/B no drops");
    waitDrain(4000);

    // Random lines: shuffled columns, skipped columns, stray out-of-range strobes.
    for (int l = 0; l < 4; l++) begin
      cnt = 0;
      for (int c = 0; c < LINE_W - 1; c++) begin
        if ($urandom_range(0, 7) != 0) begin
          order[cnt] = c;
          cnt++;
        end
      end
      for (int i = cnt - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 15) == 0) applyStimulus(LINE_W + int'($urandom_range(0, 95)), color_t'($urandom));
        applyStimulus(order[i], color_t'($urandom));
        idle(int'($urandom_range(0, 2)));
      end
      applyStimulus(LINE_W - 1, color_t'($urandom));
    end
    waitDrain(20000);
    checkStatus("random lines");

    // Reset in the middle of a stream.
    readyMode = 0;
    fillLine(0, 1'b1, '0);
    base = beatsAccepted;
    n = 0;
    while (beatsAccepted < base + 80 && n < 2000) begin
      idle(1);
      n++;
    end
    checkOutput("reached beat 80", 32'(beatsAccepted - base >= 80), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("out_valid at reset", 32'(bus.out_valid), 32'd0);
    expQ.delete();
    outstanding = 0;
    modelWrBank = 0;
    expOverflow = 1'b0;
    expDrops = 0;
    idle(3);
    reset = 1'b0;
    #1;
    checkIdleOutputs("after mid-stream reset");
    checkStatus("after mid-stream reset");
    idle(20);
    checkOutput("no stream after reset", 32'(bus.out_valid), 32'd0);

    // New line after reset streams normally.
    readyMode = 2;
    fillLine(0, 1'b1, '0);
    waitDrain(3000);
    checkStatus("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
